matrix_loader: RTL and testbench

- Upstream feeder for the 5x5 matrix-inverse engine.
- Accepts a row-major stream of 25 32-bit matrix elements over a valid/ready handshake and buffers them in a 25-entry register file.
- Pulses `start` to the engine, then serves the engine's element reads on `ram1`.
- Holds the buffer stable until the engine signals completion, then accepts the next matrix.

---
 rtl/matrix_loader.sv | 129 ++++++++++++
 tb/tb_matrix_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_loader.sv
// Input buffer for the 5x5 matrix-inverse engine: fills a 25-entry register file,
// pulses start, then serves engine reads until done_in. Option: MATRIX_LOADER_DIAG_CHECK_EN.
module matrix_loader #(
    parameter int DATA_W = 32,
    parameter int N      = 5,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] ram1,
    output logic              start,
    input  logic              done_in,
    output logic              busy,
`ifdef MATRIX_LOADER_DIAG_CHECK_EN
    output logic              diag_zero,
`endif
    output logic [ADDR_W-1:0] count
);

    localparam int DEPTH = N * N;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_START = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t            state_q;
    logic              in_ready_q;
    logic              start_q;
    logic              busy_q;
    logic [ADDR_W-1:0] count_q;
    logic [DATA_W-1:0] ram1_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              xfer;

    // in_ready_q is low only in the first cycle out of reset and outside FILL
    assign xfer = in_valid && in_ready_q;

`ifdef MATRIX_LOADER_DIAG_CHECK_EN
    logic diag_q;
    logic is_diag;

    always_comb begin
        is_diag = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (count_q == ADDR_W'(i * (N + 1))) begin
                is_diag = 1'b1;
            end
        end
    end

    assign diag_zero = diag_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FILL;
            in_ready_q <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            count_q    <= '0;
            ram1_q     <= '0;
`ifdef MATRIX_LOADER_DIAG_CHECK_EN
            diag_q     <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
            ram1_q  <= (rd_addr < DEPTH_A) ? mem_q[rd_addr] : '0;
            case (state_q)
                S_FILL: begin
                    in_ready_q <= 1'b1;
                    if (xfer) begin
                        count_q <= count_q + 1'b1;
`ifdef MATRIX_LOADER_DIAG_CHECK_EN
                        if (is_diag && (in_data == '0)) begin
                            diag_q <= 1'b1;
                        end
`endif
                        if (count_q == LAST_A) begin
                            state_q    <= S_START;
                            start_q    <= 1'b1;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                S_START: begin
                    state_q <= S_HOLD;
                    busy_q  <= 1'b1;
                end
                S_HOLD: begin
                    if (done_in) begin
                        state_q    <= S_FILL;
                        busy_q     <= 1'b0;
                        count_q    <= '0;
                        in_ready_q <= 1'b1;
`ifdef MATRIX_LOADER_DIAG_CHECK_EN
                        diag_q     <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q    <= S_FILL;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Buffer contents need no reset; they are only trusted after a full fill
    always_ff @(posedge clk) begin
        if (xfer) begin
            mem_q[count_q] <= in_data;
        end
    end

    assign in_ready = in_ready_q;
    assign start    = start_q;
    assign busy     = busy_q;
    assign count    = count_q;
    assign ram1     = ram1_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Scoreboard bench for matrix_loader: randomized fills, reads checked against a
// behavioural buffer model; start timing and read data checked by a separate monitor.
module tb_matrix_loader;

    localparam int DATA_W = 32;
    localparam int N      = 5;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = N * N;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] ram1;
    logic              start;
    logic              done_in;
    logic              busy;
    logic [ADDR_W-1:0] count;
`ifdef MATRIX_LOADER_DIAG_CHECK_EN
    logic              diag_zero;
`endif

    matrix_loader #(.DATA_W(DATA_W), .N(N), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .rd_addr  (rd_addr),
        .ram1     (ram1),
        .start    (start),
        .done_in  (done_in),
        .busy     (busy),
`ifdef MATRIX_LOADER_DIAG_CHECK_EN
        .diag_zero(diag_zero),
`endif
        .count    (count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] rd_exp_q[$];
    int          start_exp_q[$];
    logic        rd_req   = 1'b0;
    logic        rd_req_d = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: compares read data and start pulses against queued expectations
    always @(posedge clk) rd_req_d <= rd_req;

    always @(negedge clk) begin
        if (rd_req_d) begin
            chk("rd_expected", 32'(rd_exp_q.size() > 0), 32'd1);
            if (rd_exp_q.size() > 0) chk("ram1", ram1, rd_exp_q.pop_front());
        end
        if (start === 1'b1) begin
            chk("start_expected", 32'(start_exp_q.size() > 0), 32'd1);
            if (start_exp_q.size() > 0) chk("start_cycle", cyc, start_exp_q.pop_front());
        end
    end

    // gap_mode: 0 back-to-back, 1 alternate idle cycles, 2 random gaps with stray done_in
    task automatic send_matrix(input int gap_mode, input int zero_idx, input bit seq);
        int          gaps;
        logic [31:0] v;
        for (int k = 0; k < DEPTH; k++) begin
            gaps = (gap_mode == 1) ? ((k > 0) ? 1 : 0) :
                   (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            repeat (gaps) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                done_in  = (gap_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
                @(negedge clk);
            end
            done_in = 1'b0;
            v = (k == zero_idx) ? 32'd0 : (seq ? 32'(k + 1) : ($urandom | 32'd1));
            chk("in_ready_fill", 32'(in_ready), 32'd1);
            chk("count_fill", 32'(count), 32'(k));
            in_valid = 1'b1;
            in_data  = v;
            model_mem[k] = v;
            if (k == DEPTH - 1) start_exp_q.push_back(cyc + 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("in_ready_start", 32'(in_ready), 32'd0);
        chk("count_start", 32'(count), 32'(DEPTH));
        chk("busy_start", 32'(busy), 32'd0);
`ifdef MATRIX_LOADER_DIAG_CHECK_EN
        chk("diag_zero", 32'(diag_zero), 32'((zero_idx >= 0) && (zero_idx % (N + 1) == 0)));
`endif
        done_in = 1'b1;  // arrives during START and must be ignored
        @(negedge clk);
        done_in = 1'b0;
        chk("busy_hold", 32'(busy), 32'd1);
        chk("in_ready_hold", 32'(in_ready), 32'd0);
        chk("count_hold", 32'(count), 32'(DEPTH));
    endtask

    task automatic read_addr(input int a);
        rd_addr = ADDR_W'(a);
        rd_req  = 1'b1;
        rd_exp_q.push_back((a < DEPTH) ? model_mem[a] : 32'd0);
        @(negedge clk);
    endtask

    task automatic read_all();
        for (int a = 0; a < 32; a++) read_addr(a);
        for (int i = 0; i < 8; i++) read_addr(int'($urandom_range(0, 31)));
        rd_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic hold_junk();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hDEADBEEF;
            @(negedge clk);
            chk("in_ready_junk", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_matrix();
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        chk("busy_done", 32'(busy), 32'd0);
        chk("count_done", 32'(count), 32'd0);
        chk("in_ready_done", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        rd_addr  = '0;
        done_in  = 1'b0;
        @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ram1", ram1, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Sequential 1..25, directed reads, stray writes during HOLD
        send_matrix(0, -1, 1'b1);
        read_addr(0);
        read_addr(12);
        read_addr(24);
        read_addr(30);
        rd_req = 1'b0;
        hold_junk();
        read_all();
        finish_matrix();

        send_matrix(1, 12, 1'b0);
        read_all();
        finish_matrix();

        send_matrix(2, -1, 1'b0);
        read_all();
        finish_matrix();

        // Reset after 10 elements
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midfill_rst_count", 32'(count), 32'd0);
        chk("midfill_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_matrix(0, 0, 1'b0);
        read_all();

        // Reset in HOLD
        rst_n = 1'b0;
        #1;
        chk("hold_rst_busy", 32'(busy), 32'd0);
        chk("hold_rst_count", 32'(count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_matrix(2, 24, 1'b0);
        read_all();
        finish_matrix();

        repeat (3) @(negedge clk);
        chk("start_all_seen", 32'(start_exp_q.size()), 32'd0);
        chk("rd_all_seen", 32'(rd_exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
